// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush/bubble controller with memory-wait timeout.
// Optional performance counters are built only when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [4:0]       i_id_rs1,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_uses_rs2,
  input  logic [4:0]       i_ex_rd,
  input  logic             i_ex_mem_read,
  input  logic             i_ex_branch_taken,
  input  logic             i_dmem_busy,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_id_ex_write,
  output logic             o_ex_mem_write,
  output logic             o_if_id_flush,
  output logic             o_id_ex_bubble,
  output logic [1:0]       o_state,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_stall_cnt,
  output logic [CNT_W-1:0] o_flush_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_next;
  logic              r_timeout;
  logic              w_lu;

  assign w_lu = i_ex_mem_read & (i_ex_rd != 5'd0) &
                ((i_ex_rd == i_id_rs1) | (i_id_uses_rs2 & (i_ex_rd == i_id_rs2)));

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= ST_RUN;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_wait_cnt_next;
      if (w_wait_cnt_next == WAIT_MAX) begin
        r_timeout <= 1'b1;
      end
    end
  end

  // Busy outranks every state; a MEM_WAIT cycle without busy is evaluated as RUN.
  always_comb begin
    o_pc_write     = 1'b1;
    o_if_id_write  = 1'b1;
    o_id_ex_write  = 1'b1;
    o_ex_mem_write = 1'b1;
    o_if_id_flush  = 1'b0;
    o_id_ex_bubble = 1'b0;
    w_next_state   = ST_RUN;
    if (i_reset) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_write  = 1'b0;
      o_ex_mem_write = 1'b0;
    end else if (i_dmem_busy) begin
      o_pc_write     = 1'b0;
      o_if_id_write  = 1'b0;
      o_id_ex_write  = 1'b0;
      o_ex_mem_write = 1'b0;
      w_next_state   = ST_MEM_WAIT;
    end else begin
      case (r_state)
        ST_RUN, ST_MEM_WAIT: begin
          if (i_ex_branch_taken) begin
            o_if_id_flush  = 1'b1;
            o_id_ex_bubble = 1'b1;
            w_next_state   = ST_FLUSH;
          end else if (w_lu) begin
            o_pc_write     = 1'b0;
            o_if_id_write  = 1'b0;
            o_id_ex_bubble = 1'b1;
            w_next_state   = ST_LU_STALL;
          end
        end
        default: w_next_state = ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_wait_cnt_next = r_wait_cnt;
    if (r_state == ST_MEM_WAIT) begin
      if (i_dmem_busy) begin
        if (r_wait_cnt != WAIT_MAX) begin
          w_wait_cnt_next = r_wait_cnt + 1'b1;
        end
      end else begin
        w_wait_cnt_next = '0;
      end
    end
  end

  assign o_state   = r_state;
  assign o_timeout = r_timeout;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (!o_pc_write && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (o_if_id_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;
`else
  assign o_stall_cnt = '0;
  assign o_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl (TIMEOUT=8, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  localparam int TO   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic [4:0]    rs1, rs2, exrd;
  logic          uses2, memrd, br, busy;
  logic          pc_w, ifid_w, idex_w, exmem_w, flush, bubble, tout;
  logic [1:0]    st;
  logic [CW-1:0] scnt, fcnt;

  pipeline_hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_id_rs1(rs1), .i_id_rs2(rs2), .i_id_uses_rs2(uses2),
    .i_ex_rd(exrd), .i_ex_mem_read(memrd),
    .i_ex_branch_taken(br), .i_dmem_busy(busy),
    .o_pc_write(pc_w), .o_if_id_write(ifid_w), .o_id_ex_write(idex_w), .o_ex_mem_write(exmem_w),
    .o_if_id_flush(flush), .o_id_ex_bubble(bubble),
    .o_state(st), .o_timeout(tout),
    .o_stall_cnt(scnt), .o_flush_cnt(fcnt)
  );

  typedef struct {
    logic [3:0]    en;
    logic          fl;
    logic          bb;
    logic [1:0]    st;
    logic          to;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
    bit            regs;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: mode 0=RUN 1=LU_STALL 2=FLUSH 3=MEM_WAIT, plain integer bookkeeping.
  int m_mode  = 0;
  int m_wait  = 0;
  bit m_to    = 0;
  int m_sc    = 0;
  int m_fc    = 0;
  bit m_known = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("enables", {28'd0, pc_w, ifid_w, idex_w, exmem_w}, {28'd0, e.en});
        chk("flush", {31'd0, flush}, {31'd0, e.fl});
        chk("bubble", {31'd0, bubble}, {31'd0, e.bb});
        if (e.regs) begin
          chk("state", {30'd0, st}, {30'd0, e.st});
          chk("timeout", {31'd0, tout}, {31'd0, e.to});
          chk("stall_cnt", {28'd0, scnt}, {28'd0, e.sc});
          chk("flush_cnt", {28'd0, fcnt}, {28'd0, e.fc});
        end
      end
    end
  end

  task automatic step(input bit r, input bit b_busy, input bit b_br, input bit b_memrd,
                      input logic [4:0] v_exrd, input logic [4:0] v_rs1,
                      input logic [4:0] v_rs2, input bit b_uses2);
    exp_t e;
    bit   lu;
    bit   run_like;
    int   nxt;
    rst = r; busy = b_busy; br = b_br; memrd = b_memrd;
    exrd = v_exrd; rs1 = v_rs1; rs2 = v_rs2; uses2 = b_uses2;

    lu       = b_memrd && (v_exrd != 0) && ((v_exrd == v_rs1) || (b_uses2 && (v_exrd == v_rs2)));
    run_like = (m_mode == 0) || (m_mode == 3 && !b_busy);
    e.fl = 1'b0;
    e.bb = 1'b0;
    nxt  = 0;
    if (r) begin
      e.en = 4'b0000;
    end else if (b_busy) begin
      e.en = 4'b0000;
      nxt  = 3;
    end else if (run_like && b_br) begin
      e.en = 4'b1111; e.fl = 1'b1; e.bb = 1'b1; nxt = 2;
    end else if (run_like && lu) begin
      e.en = 4'b0011; e.bb = 1'b1; nxt = 1;
    end else begin
      e.en = 4'b1111;
    end
    e.st   = 2'(m_mode);
    e.to   = m_to;
    e.sc   = CW'(m_sc);
    e.fc   = CW'(m_fc);
    e.regs = m_known;
    sb_q.push_back(e);

    if (r) begin
      m_mode = 0; m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0; m_known = 1;
    end else begin
      if (m_mode == 3) begin
        if (b_busy) begin
          if (m_wait < TO) m_wait++;
          if (m_wait == TO) m_to = 1;
        end else begin
          m_wait = 0;
        end
      end
`ifdef HAZARD_PERF_CNT_EN
      if (!e.en[3] && m_sc < CMAX) m_sc++;
      if (e.fl && m_fc < CMAX) m_fc++;
`endif
      m_mode = nxt;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 5'd0, 5'd1, 5'd2, 1'b1);
  endtask

  initial begin
    int burst;
    int guard;
    rst = 1'b1; busy = 1'b0; br = 1'b0; memrd = 1'b0;
    exrd = '0; rs1 = '0; rs2 = '0; uses2 = 1'b0;
    @(posedge clk);
    #1;
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);

    // load-use on rs1, then one advance cycle in LU_STALL
    step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    idle(2);
    // x0 never stalls; rs2 only matters when read
    step(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1);
    step(0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 0);
    step(0, 0, 0, 1, 5'd7, 5'd3, 5'd7, 1);
    idle(2);
    // branch beats load-use; branch ignored in FLUSH
    step(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
    step(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
    idle(2);
    // busy beats everything; release cycle behaves as RUN
    for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0);
    step(0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 0);
    idle(2);
    // timeout and its stickiness
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(3);
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(1);
    // reset mid-MEM_WAIT and mid-stall
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    step(1, 1, 1, 1, 5'd5, 5'd5, 5'd0, 0);
    step(0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    step(1, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0);
    // stall counter saturation
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0);
    for (int i = 0; i < 20; i++) step(0, 0, (i % 2) == 0, 0, 5'd0, 5'd0, 5'd0, 0);
    idle(2);

    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      bit b;
      if (burst > 0) begin
        b = 1; burst--;
      end else if ($urandom_range(0, 11) == 0) begin
        b = 1; burst = $urandom_range(0, 12);
      end else begin
        b = 0;
      end
      step($urandom_range(0, 149) == 0, b, $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1);
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
